// File: rtl/core_bus_avalon_pkg.sv
// Shared bus types and constants for the core-to-Avalon bridge.
package core_bus_avalon_pkg;
    typedef logic [29:0] ptr;
    typedef logic [31:0] word;

    // Read data returned to the core when the watchdog forces completion.
    localparam word BUS_TIMEOUT_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/core_bus_avalon.sv
// Bridges the core's single-outstanding start/ready bus onto an Avalon-MM master,
// with a watchdog that forces completion if the slave never answers.
module core_bus_avalon
    import core_bus_avalon_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  ptr          bus_addr,
    input  logic        bus_start,
    input  logic        bus_write,
    input  word         bus_data_wr,
    output logic        bus_ready,
    output word         bus_data_rd,
    output logic [31:0] avl_address,
    output logic        avl_read,
    output logic        avl_write,
    output logic [31:0] avl_writedata,
    output logic [3:0]  avl_byteenable,
    input  logic        avl_waitrequest,
    input  logic [31:0] avl_readdata,
    input  logic        avl_readdatavalid,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, DONE} state_e;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_e          state_q;
    logic            wr_q;
    logic [CW-1:0]   cnt_q;
    logic            ready_q;
    word             rdata_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            rd_en_q;
    logic            wr_en_q;
    logic            to_q;
    logic            expire;

    // Only fires when the normal exit is not taken; the FSM checks the exit first.
    assign expire = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_start) begin
                        wr_q    <= bus_write;
                        addr_q  <= {bus_addr, 2'b00};
                        wdata_q <= bus_data_wr;
                        rd_en_q <= !bus_write;
                        wr_en_q <= bus_write;
                        cnt_q   <= '0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!avl_waitrequest) begin
                        rd_en_q <= 1'b0;
                        wr_en_q <= 1'b0;
                        ready_q <= wr_q;
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= wr_q ? DONE : RDWAIT;
                    end else if (expire) begin
                        rd_en_q <= 1'b0;
                        wr_en_q <= 1'b0;
                        ready_q <= 1'b1;
                        to_q    <= 1'b1;
                        if (!wr_q) rdata_q <= BUS_TIMEOUT_DATA;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RDWAIT: begin
                    if (avl_readdatavalid) begin
                        rdata_q <= avl_readdata;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else if (expire) begin
                        ready_q <= 1'b1;
                        to_q    <= 1'b1;
                        rdata_q <= BUS_TIMEOUT_DATA;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_ready      = ready_q;
    assign bus_data_rd    = rdata_q;
    assign avl_address    = addr_q;
    assign avl_read       = rd_en_q;
    assign avl_write      = wr_en_q;
    assign avl_writedata  = wdata_q;
    assign avl_byteenable = 4'b1111;
    assign timeout        = to_q;
endmodule
